// File: rtl/bk_tape_in.sv
// bk_tape_in: cassette input front end for the BK0010/BK0011M core.
// Synchronises and glitch-filters the raw tape pin into tape_bit. It also
// measures half-periods between filtered edges, flags tape activity, and
// holds the tape motor latch written through the system register.
// Optional feature macro: BK_TAPE_PERIOD_EN builds the period counter,
// period/period_valid outputs and the activity detector. Without it those
// outputs are tied to 0.
module bk_tape_in #(
  parameter int FILT_LEN  = 8,
  parameter int ACT_EDGES = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_12mp,
  input  logic        tape_in,
  input  logic        sysreg_sel,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] bus_din,
  output logic        tape_bit,
  output logic        motor_on,
  output logic [11:0] period,
  output logic        period_valid,
  output logic        tape_active
);

  localparam logic [3:0]  FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [3:0]  ACT_MAX  = 4'(ACT_EDGES);
  localparam logic [11:0] PCNT_MAX = 12'hFFF;

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] fcnt;
  logic       flip_vld_p0;
  logic       wr_stb;
  logic       wr_stb_d;
  logic       unused_bits;

  // Stage p0/p1: two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= tape_in;
      sync_p1 <= sync_p0;
    end
  end

  // Filter: count sampled ticks that disagree with tape_bit and request a flip
  // on the FILT_LEN-th; the flip request is registered so tape_bit changes on
  // the clock after the deciding tick.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fcnt        <= 4'd0;
      flip_vld_p0 <= 1'b0;
    end else begin
      flip_vld_p0 <= 1'b0;
      if (flip_vld_p0) begin
        fcnt <= 4'd0;
      end else if (ce_12mp) begin
        if (sync_p1 != tape_bit) begin
          if (fcnt == FILT_MAX) begin
            fcnt        <= 4'd0;
            flip_vld_p0 <= 1'b1;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end else begin
          fcnt <= 4'd0;
        end
      end
    end
  end

  // Stage p1 boundary: filtered level, idles high
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tape_bit <= 1'b1;
    end else if (flip_vld_p0) begin
      tape_bit <= ~tape_bit;
    end
  end

`ifdef BK_TAPE_PERIOD_EN
  logic [11:0] pcnt;
  logic [3:0]  ecnt;

  function automatic logic [11:0] sat_inc_pcnt(input logic [11:0] v);
    return (v == PCNT_MAX) ? v : v + 12'd1;
  endfunction

  function automatic logic [3:0] sat_inc_ecnt(input logic [3:0] v);
    return (v >= ACT_MAX) ? ACT_MAX : v + 4'd1;
  endfunction

  // Half-period measurement and activity count, updated on the tape_bit flip
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pcnt         <= 12'd0;
      ecnt         <= 4'd0;
      period       <= 12'd0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= flip_vld_p0;
      if (flip_vld_p0) begin
        period <= pcnt;
        pcnt   <= 12'd0;
        ecnt   <= (pcnt == PCNT_MAX) ? 4'd1 : sat_inc_ecnt(ecnt);
      end else begin
        if (ce_12mp) begin
          pcnt <= sat_inc_pcnt(pcnt);
        end
        if (pcnt == PCNT_MAX) begin
          ecnt <= 4'd0;
        end
      end
    end
  end

  assign tape_active = (ecnt == ACT_MAX);
`else
  assign period       = 12'd0;
  assign period_valid = 1'b0;
  assign tape_active  = 1'b0;
`endif

  assign wr_stb      = bus_stb & sysreg_sel & bus_we;
  assign unused_bits = &{1'b0, bus_wtbt[1], bus_din[15:8], bus_din[6:0]};

  // Motor latch: low-byte write on the rising edge of the sysreg write strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_stb_d <= 1'b0;
      motor_on <= 1'b0;
    end else begin
      wr_stb_d <= wr_stb;
      if (wr_stb && !wr_stb_d && bus_wtbt[0]) begin
        motor_on <= ~bus_din[7];
      end
    end
  end

endmodule

// File: tb/tb_bk_tape_in.sv
// Testbench for bk_tape_in: tick-level reference model with a scoreboard of
// expected filtered edges, checked by an independent monitor.
module tb_bk_tape_in;

  localparam int FILT_LEN  = 8;
  localparam int ACT_EDGES = 8;
  localparam int PMAX      = 4095;
`ifdef BK_TAPE_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_12mp = 1'b0;
  logic        tape_in = 1'b1;
  logic        sysreg_sel = 1'b0;
  logic        bus_stb = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_wtbt = 2'b00;
  logic [15:0] bus_din = 16'd0;
  logic        tape_bit;
  logic        motor_on;
  logic [11:0] period;
  logic        period_valid;
  logic        tape_active;

  bk_tape_in #(.FILT_LEN(FILT_LEN), .ACT_EDGES(ACT_EDGES)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_12mp(ce_12mp), .tape_in(tape_in),
    .sysreg_sel(sysreg_sel), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_wtbt(bus_wtbt), .bus_din(bus_din), .tape_bit(tape_bit),
    .motor_on(motor_on), .period(period), .period_valid(period_valid),
    .tape_active(tape_active)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int   at_cyc;
    logic bitv;
    int   per;
    logic act;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tick-level view of the filtered level, time since the
  // last edge and the run of unsaturated edges.
  logic m_y;
  int   m_run, m_tk, m_prev, m_act, m_per;
  logic m_motor = 1'b0;

  task automatic model_reset();
    m_y = 1'b1; m_run = 0; m_tk = 0; m_prev = 0; m_act = 0; m_per = 0;
    m_motor = 1'b0;
  endtask

  task automatic model_tick(input logic s, input int c);
    int   d;
    bit   tog;
    exp_t e;
    tog = 1'b0;
    m_tk++;
    if (s != m_y) begin
      m_run++;
      if (m_run == FILT_LEN) begin
        tog   = 1'b1;
        m_y   = ~m_y;
        m_run = 0;
        d     = m_tk - m_prev;
        m_per = (d >= PMAX) ? PMAX : d;
        if (d >= PMAX) m_act = 1;
        else m_act = (m_act >= ACT_EDGES) ? ACT_EDGES : m_act + 1;
        m_prev = m_tk;
        e.at_cyc = c + 1; e.bitv = m_y; e.per = m_per; e.act = (m_act == ACT_EDGES);
        exp_q.push_back(e);
      end
    end else begin
      m_run = 0;
    end
    if (!tog && (m_tk - m_prev >= PMAX)) m_act = 0;
  endtask

  // One sampling tick: present the level, then three clocks with ce on the last
  task automatic tick(input logic lvl);
    tape_in = lvl;
    @(posedge clk_sys); #1;
    chk("tape_bit_level", int'(tape_bit), int'(m_y));
    chk("tape_active_level", int'(tape_active), PER_EN ? int'(m_act == ACT_EDGES) : 0);
    chk("period_hold", int'(period), PER_EN ? m_per : 0);
    @(posedge clk_sys); #1;
    ce_12mp = 1'b1;
    @(posedge clk_sys); #1;
    ce_12mp = 1'b0;
    model_tick(lvl, cyc);
  endtask

  task automatic ticks(input logic lvl, input int n);
    for (int i = 0; i < n; i++) tick(lvl);
  endtask

  task automatic chk_reset_vals();
    chk("rst_tape_bit", int'(tape_bit), 1);
    chk("rst_motor_on", int'(motor_on), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_period_valid", int'(period_valid), 0);
    chk("rst_tape_active", int'(tape_active), 0);
  endtask

  task automatic bus_wr(input logic sel, input logic [1:0] be, input logic [15:0] d,
                        input int hold);
    sysreg_sel = sel; bus_we = 1'b1; bus_wtbt = be; bus_din = d; bus_stb = 1'b1;
    if (sel && be[0]) m_motor = ~d[7];
    @(posedge clk_sys); #1;
    chk("motor_on_write", int'(motor_on), int'(m_motor));
    for (int i = 1; i < hold; i++) begin
      bus_din = d ^ 16'o000200;
      @(posedge clk_sys); #1;
      chk("motor_on_held", int'(motor_on), int'(m_motor));
    end
    bus_stb = 1'b0; bus_we = 1'b0; sysreg_sel = 1'b0;
    @(posedge clk_sys); #1;
    chk("motor_on_after", int'(motor_on), int'(m_motor));
  endtask

  // Monitor: every filtered edge must match the head of the scoreboard
  logic last_tb = 1'b1;
  always @(negedge clk_sys) begin
    exp_t e;
    if (!reset_n) begin
      last_tb = 1'b1;
    end else if (tape_bit !== last_tb) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_edge", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("edge_cycle", cyc, e.at_cyc);
        chk("edge_level", int'(tape_bit), int'(e.bitv));
        chk("edge_period_valid", int'(period_valid), PER_EN ? 1 : 0);
        chk("edge_period", int'(period), PER_EN ? e.per : 0);
        chk("edge_tape_active", int'(tape_active), PER_EN ? int'(e.act) : 0);
      end
      last_tb = tape_bit;
    end else begin
      chk("pv_without_edge", int'(period_valid), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic cur;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_vals();
    reset_n = 1'b1;

    // Idle line after reset
    ticks(1'b1, 10000);

    // Glitch one tick shorter than the filter
    ticks(1'b0, FILT_LEN - 1);
    ticks(1'b1, 20);

    // Square wave, 100 ticks per half-period
    cur = 1'b1;
    for (int h = 0; h < 20; h++) begin
      cur = ~cur;
      ticks(cur, 100);
    end

    // Dropout past saturation, then resume
    ticks(cur, 4200);
    for (int h = 0; h < 4; h++) begin
      cur = ~cur;
      ticks(cur, 100);
    end

    // Motor latch writes
    bus_wr(1'b1, 2'b11, 16'o000000, 1);
    bus_wr(1'b1, 2'b01, 16'o000200, 1);
    bus_wr(1'b1, 2'b10, 16'o000000, 1);
    bus_wr(1'b1, 2'b11, 16'o000000, 5);
    bus_wr(1'b0, 2'b11, 16'o000200, 1);
    bus_wr(1'b1, 2'b01, 16'o000200, 1);
    bus_wr(1'b1, 2'b11, 16'o000000, 1);

    // Randomised half-periods, short ones act as glitches
    for (int h = 0; h < 20; h++) begin
      cur = ~cur;
      ticks(cur, int'($urandom_range(1, 200)));
    end

    // Reset in the middle of a measurement
    for (int h = 0; h < 3; h++) begin
      cur = ~cur;
      ticks(cur, 100);
    end
    ticks(~cur, 50);
    repeat (2) @(posedge clk_sys);
    #1;
    chk("sb_empty_before_reset", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals();
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    for (int h = 0; h < 3; h++) begin
      cur = ~cur;
      ticks(cur, 100);
    end

    repeat (5) @(posedge clk_sys);
    #1;
    chk("sb_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
